// File: rtl/traffic_light_monitor.sv
// ----------------------------------------------------------------------------
// traffic_light_monitor
//
// Independent conflict monitor for a traffic-light controller. It samples the
// lamp outputs and the car sensor, checks the lamp encoding, the phase order
// and the phase durations, and latches the first violation as a fault code.
// While a fault is latched it requests fail-safe flashing red.
//
// Ports:
//   quartzClock  in   system clock, rising edge
//   resetN       in   synchronous reset, active low
//   green        in   green lamp from controller
//   yellow       in   yellow lamp from controller
//   red          in   red lamp from controller
//   carDetected  in   vehicle sensor (same signal the controller uses)
//   clearFault   in   single-cycle request to clear a latched fault
//   fault        out  a fault is latched
//   faultCode    out  code of the first latched fault (0 when fault=0)
//   flashRed     out  flash request, toggles every tick while faulted
//   phaseSec     out  ticks spent in the current phase, saturating at 31
// ----------------------------------------------------------------------------
module traffic_light_monitor #(
    parameter int unsigned TICK_DIV   = 256,
    parameter int unsigned GLITCH_CYC = 2,
    parameter int unsigned YELLOW_MIN = 3,
    parameter int unsigned GREEN_MAX  = 17,
    parameter int unsigned RED_MAX    = 17
) (
    input  logic       quartzClock,
    input  logic       resetN,
    input  logic       green,
    input  logic       yellow,
    input  logic       red,
    input  logic       carDetected,
    input  logic       clearFault,
    output logic       fault,
    output logic [2:0] faultCode,
    output logic       flashRed,
    output logic [4:0] phaseSec
);

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_RED    = 2'd2
    } phase_e;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 32'd1);
    localparam logic [4:0]  GLITCH_C  = 5'(GLITCH_CYC);
    localparam logic [4:0]  SEC_SAT   = 5'd31;

    // Registered copies of the monitored inputs
    logic   g_q, y_q, r_q, car_q;

    // State flops and their next values
    phase_e      prev_phase_q, prev_phase_d;
    logic [15:0] presc_q, presc_d;
    logic [4:0]  phase_sec_q, phase_sec_d;
    logic [3:0]  dark_cnt_q, dark_cnt_d;
    logic [3:0]  multi_cnt_q, multi_cnt_d;
    logic        fault_q, fault_d;
    logic [2:0]  code_q, code_d;
    logic        flash_q, flash_d;

    // Combinational decode and checks
    logic   tick_s;
    logic   lamp_dark_s, lamp_multi_s, lamp_single_s;
    phase_e lamp_phase_s, legal_next_s;
    logic   phase_chg_s;
    logic   dark_flt_s, multi_flt_s, seq_flt_s, yshort_flt_s;
    logic   gstuck_flt_s, rstuck_flt_s;
    logic   det_s;
    logic [2:0] det_code_s;

    // State register: all flops, synchronous active-low reset
    always_ff @(posedge quartzClock) begin
        if (!resetN) begin
            g_q          <= 1'b0;
            y_q          <= 1'b0;
            r_q          <= 1'b0;
            car_q        <= 1'b0;
            prev_phase_q <= PH_RED;
            presc_q      <= 16'd0;
            phase_sec_q  <= 5'd0;
            dark_cnt_q   <= 4'd0;
            multi_cnt_q  <= 4'd0;
            fault_q      <= 1'b0;
            code_q       <= 3'd0;
            flash_q      <= 1'b0;
        end else begin
            g_q          <= green;
            y_q          <= yellow;
            r_q          <= red;
            car_q        <= carDetected;
            prev_phase_q <= prev_phase_d;
            presc_q      <= presc_d;
            phase_sec_q  <= phase_sec_d;
            dark_cnt_q   <= dark_cnt_d;
            multi_cnt_q  <= multi_cnt_d;
            fault_q      <= fault_d;
            code_q       <= code_d;
            flash_q      <= flash_d;
        end
    end

    // Lamp decode and phase-change detection on the registered lamps
    always_comb begin
        lamp_dark_s   = ~(g_q | y_q | r_q);
        lamp_multi_s  = (g_q & y_q) | (g_q & r_q) | (y_q & r_q);
        lamp_single_s = ~lamp_dark_s & ~lamp_multi_s;
        case ({g_q, y_q, r_q})
            3'b100:  lamp_phase_s = PH_GREEN;
            3'b010:  lamp_phase_s = PH_YELLOW;
            3'b001:  lamp_phase_s = PH_RED;
            default: lamp_phase_s = prev_phase_q;
        endcase
        phase_chg_s = lamp_single_s && (lamp_phase_s != prev_phase_q);
        case (prev_phase_q)
            PH_GREEN:  legal_next_s = PH_YELLOW;
            PH_YELLOW: legal_next_s = PH_RED;
            PH_RED:    legal_next_s = PH_GREEN;
            default:   legal_next_s = PH_RED;
        endcase
    end

    // Next state for prescaler, phase tracking and glitch counters
    always_comb begin
        tick_s = (presc_q == TICK_LAST);
        if (tick_s) begin
            presc_d = 16'd0;
        end else begin
            presc_d = presc_q + 16'd1;
        end

        if (phase_chg_s) begin
            prev_phase_d = lamp_phase_s;
        end else begin
            prev_phase_d = prev_phase_q;
        end

        // A phase change clears the counter even on a tick cycle
        if (phase_chg_s) begin
            phase_sec_d = 5'd0;
        end else if (tick_s && (phase_sec_q != SEC_SAT)) begin
            phase_sec_d = phase_sec_q + 5'd1;
        end else begin
            phase_sec_d = phase_sec_q;
        end

        // Glitch counters saturate at the threshold so they cannot wrap
        if (!lamp_dark_s) begin
            dark_cnt_d = 4'd0;
        end else if ({1'b0, dark_cnt_q} >= GLITCH_C) begin
            dark_cnt_d = dark_cnt_q;
        end else begin
            dark_cnt_d = dark_cnt_q + 4'd1;
        end

        if (!lamp_multi_s) begin
            multi_cnt_d = 4'd0;
        end else if ({1'b0, multi_cnt_q} >= GLITCH_C) begin
            multi_cnt_d = multi_cnt_q;
        end else begin
            multi_cnt_d = multi_cnt_q + 4'd1;
        end
    end

    // Fault detection, priority encoding and fault latch next state
    always_comb begin
        // This cycle completes the run when count-so-far plus one reaches it
        dark_flt_s   = lamp_dark_s  && (({1'b0, dark_cnt_q}  + 5'd1) >= GLITCH_C);
        multi_flt_s  = lamp_multi_s && (({1'b0, multi_cnt_q} + 5'd1) >= GLITCH_C);
        // Any move to red is legal when no car waits: the controller forces red
        seq_flt_s    = phase_chg_s && (lamp_phase_s != legal_next_s)
                       && !((lamp_phase_s == PH_RED) && !car_q);
        yshort_flt_s = phase_chg_s && (prev_phase_q == PH_YELLOW)
                       && (lamp_phase_s == PH_RED) && car_q
                       && (32'(phase_sec_q) < YELLOW_MIN);
        // Stuck checks look at next-state values so they latch on the tick edge
        gstuck_flt_s = (prev_phase_d == PH_GREEN) && (32'(phase_sec_d) > GREEN_MAX);
        rstuck_flt_s = (prev_phase_d == PH_RED) && car_q
                       && (32'(phase_sec_d) > RED_MAX);

        if (dark_flt_s) begin
            det_code_s = 3'd1;
        end else if (multi_flt_s) begin
            det_code_s = 3'd2;
        end else if (seq_flt_s) begin
            det_code_s = 3'd3;
        end else if (yshort_flt_s) begin
            det_code_s = 3'd4;
        end else if (gstuck_flt_s) begin
            det_code_s = 3'd5;
        end else if (rstuck_flt_s) begin
            det_code_s = 3'd6;
        end else begin
            det_code_s = 3'd0;
        end
        det_s = (det_code_s != 3'd0);

        // A fresh fault (or one detected during a clear) latches with flash on
        if (det_s && (!fault_q || clearFault)) begin
            fault_d = 1'b1;
            code_d  = det_code_s;
            flash_d = 1'b1;
        end else if (fault_q && clearFault) begin
            fault_d = 1'b0;
            code_d  = 3'd0;
            flash_d = 1'b0;
        end else if (fault_q) begin
            fault_d = 1'b1;
            code_d  = code_q;
            flash_d = tick_s ? ~flash_q : flash_q;
        end else begin
            fault_d = 1'b0;
            code_d  = 3'd0;
            flash_d = 1'b0;
        end
    end

    // Outputs come straight from flops
    always_comb begin
        fault     = fault_q;
        faultCode = code_q;
        flashRed  = flash_q;
        phaseSec  = phase_sec_q;
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       green, yellow, red, car, clr;
    logic       fault;
    logic [2:0] code;
    logic       flash;
    logic [4:0] psec;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    traffic_light_monitor #(
        .TICK_DIV   (4),
        .GLITCH_CYC (2),
        .YELLOW_MIN (3),
        .GREEN_MAX  (17),
        .RED_MAX    (17)
    ) dut (
        .quartzClock (clk),
        .resetN      (rst_n),
        .green       (green),
        .yellow      (yellow),
        .red         (red),
        .carDetected (car),
        .clearFault  (clr),
        .fault       (fault),
        .faultCode   (code),
        .flashRed    (flash),
        .phaseSec    (psec)
    );

    // Inputs held for cyc edges, then outputs checked; -1 means don't care
    typedef struct {
        logic [2:0] gyr;
        logic       car;
        logic       clr;
        int         cyc;
        int         e_fault;
        int         e_code;
        int         e_flash;
        int         e_psec;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [2:0] gyr, input logic c, input logic cl, input int cyc,
                       input int ef, input int ec, input int efl, input int eps);
        vec_t v;
        v.gyr = gyr; v.car = c; v.clr = cl; v.cyc = cyc;
        v.e_fault = ef; v.e_code = ec; v.e_flash = efl; v.e_psec = eps;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] gyr, input logic c, input logic cl);
        {green, yellow, red} = gyr;
        car = c;
        clr = cl;
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Edge numbers below count edges after reset release; ticks on multiples of 4
        add(3'b001, 1'b1, 1'b0, 40, 0, 0, 0, 10);  // E40  red dwell 10 ticks
        add(3'b100, 1'b1, 1'b0,  2, 0, 0, 0,  0);  // E42  red->green, psec cleared
        add(3'b100, 1'b1, 1'b0, 40, 0, 0, 0, 10);  // E82  green dwell
        add(3'b010, 1'b1, 1'b0,  2, 0, 0, 0,  0);  // E84  clear beats tick
        add(3'b010, 1'b1, 1'b0, 20, 0, 0, 0,  5);  // E104 yellow dwell
        add(3'b001, 1'b1, 1'b0,  2, 0, 0, 0,  0);  // E106 yellow->red legal
        add(3'b001, 1'b1, 1'b0, 40, 0, 0, 0, 10);  // E146
        add(3'b100, 1'b1, 1'b0,  2, 0, 0, 0,  0);  // E148 red->green
        add(3'b001, 1'b1, 1'b0,  2, 1, 3, 1, -1);  // E150 green->red with car: code 3
        add(3'b001, 1'b1, 1'b1,  1, 0, 0, 0, -1);  // E151 clear
        add(3'b001, 1'b0, 1'b0,  1, 0, 0, 0, -1);  // E152
        add(3'b100, 1'b0, 1'b0,  2, 0, 0, 0,  0);  // E154
        add(3'b001, 1'b0, 1'b0,  3, 0, 0, 0,  0);  // E157 green->red without car: legal
        add(3'b110, 1'b0, 1'b0,  1, 0, 0, -1, -1); // E158 one-cycle multi
        add(3'b100, 1'b0, 1'b0,  3, 0, 0, 0, -1);  // E161 glitch filtered
        add(3'b110, 1'b0, 1'b0,  3, 1, 2, 1, -1);  // E164 two-cycle multi: code 2
        add(3'b100, 1'b0, 1'b0,  2, 1, 2, -1, -1); // E166
        add(3'b100, 1'b0, 1'b1,  1, 0, 0, 0, -1);  // E167 clear
        add(3'b000, 1'b0, 1'b0,  1, 0, 0, 0, -1);  // E168 alternate dark/multi
        add(3'b110, 1'b0, 1'b0,  1, 0, 0, 0, -1);  // E169
        add(3'b000, 1'b0, 1'b0,  1, 0, 0, 0, -1);  // E170
        add(3'b110, 1'b0, 1'b0,  1, 0, 0, 0, -1);  // E171
        add(3'b100, 1'b0, 1'b0,  3, 0, 0, 0, -1);  // E174
        add(3'b010, 1'b1, 1'b0, 10, 0, 0, 0,  2);  // E184 yellow 2 ticks
        add(3'b001, 1'b1, 1'b0,  2, 1, 4, 1, -1);  // E186 short yellow: code 4
        add(3'b001, 1'b1, 1'b0,  2, 1, 4, 0, -1);  // E188 flash toggles on tick
        add(3'b001, 1'b1, 1'b0,  3, 1, 4, 0, -1);  // E191
        add(3'b001, 1'b1, 1'b0,  1, 1, 4, 1, -1);  // E192 toggles again
        add(3'b001, 1'b1, 1'b1,  1, 0, 0, 0, -1);  // E193 clear while red stable
        add(3'b001, 1'b1, 1'b0,  4, 0, 0, 0, -1);  // E197
        add(3'b100, 1'b1, 1'b0,  2, 0, 0, 0,  0);  // E199 start green hold
        add(3'b100, 1'b1, 1'b0, 68, 0, 0, 0, 17);  // E267 at limit
        add(3'b100, 1'b1, 1'b0,  1, 1, 5, 1, 18);  // E268 tick 18: code 5
        add(3'b100, 1'b1, 1'b1,  1, 1, 5, -1, -1); // E269 clear re-latches
        add(3'b100, 1'b1, 1'b0,  1, 1, 5, -1, -1); // E270
        add(3'b110, 1'b1, 1'b0,  4, 1, 5, -1, -1); // E274 multi cannot overwrite
        add(3'b100, 1'b1, 1'b0, 60, 1, 5, -1, 31); // E334 psec saturates

        // Reset state
        rst_n = 1'b0;
        drive(3'b001, 1'b1, 1'b0);
        edges(3);
        chk("reset_fault", 32'(fault), 0);
        chk("reset_code",  32'(code),  0);
        chk("reset_flash", 32'(flash), 0);
        chk("reset_psec",  32'(psec),  0);

        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].gyr, vecs[i].car, vecs[i].clr);
            edges(vecs[i].cyc);
            chk($sformatf("vec%0d_fault", i), 32'(fault), vecs[i].e_fault);
            chk($sformatf("vec%0d_code", i),  32'(code),  vecs[i].e_code);
            if (vecs[i].e_flash >= 0)
                chk($sformatf("vec%0d_flash", i), 32'(flash), vecs[i].e_flash);
            if (vecs[i].e_psec >= 0)
                chk($sformatf("vec%0d_psec", i), 32'(psec), vecs[i].e_psec);
        end

        // Reset while fault 5 is latched
        rst_n = 1'b0;
        drive(3'b001, 1'b1, 1'b0);
        edges(1);
        chk("midrst_fault", 32'(fault), 0);
        chk("midrst_code",  32'(code),  0);
        chk("midrst_flash", 32'(flash), 0);
        chk("midrst_psec",  32'(psec),  0);

        // Dark latency: sampled at edge N, fault visible after N+2
        rst_n = 1'b1;
        edges(4);
        drive(3'b000, 1'b1, 1'b0);
        edges(1);
        chk("dark_n0_fault", 32'(fault), 0);
        edges(1);
        chk("dark_n1_fault", 32'(fault), 0);
        edges(1);
        chk("dark_n2_fault", 32'(fault), 1);
        chk("dark_n2_code",  32'(code),  1);
        chk("dark_n2_flash", 32'(flash), 1);

        // Red stuck with a waiting car: latches on the 18th tick edge
        rst_n = 1'b0;
        drive(3'b001, 1'b1, 1'b0);
        edges(1);
        rst_n = 1'b1;
        edges(71);
        chk("rstuck_pre_fault", 32'(fault), 0);
        chk("rstuck_pre_psec",  32'(psec),  17);
        edges(1);
        chk("rstuck_fault", 32'(fault), 1);
        chk("rstuck_code",  32'(code),  6);
        chk("rstuck_psec",  32'(psec),  18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
